// File: rtl/i2c_multi_read_seq_if.sv
// i2c_multi_read_seq_if: command port between the read sequencer and i2c_sys_top
interface i2c_multi_read_seq_if;
  logic       sys_start;
  logic [6:0] sys_slave_addr;
  logic       sys_done;
  logic [7:0] sys_rd_data;
  modport master (output sys_start, sys_slave_addr, input sys_done, sys_rd_data);
  modport slave (input sys_start, sys_slave_addr, output sys_done, sys_rd_data);
endinterface

// File: rtl/i2c_multi_read_seq.sv
// i2c_multi_read_seq: one start reads a byte from every table slave in the requester's domain
module i2c_multi_read_seq #(
  parameter int                   NUM_SLV    = 4,
  parameter int                   IDX_W      = 2,
  parameter logic [NUM_SLV*7-1:0] SLV_ADDRS  = {7'h40, 7'h30, 7'h20, 7'h10},
  parameter logic [NUM_SLV-1:0]   SLV_DOMAIN = 4'b1010,
  parameter int                   TO_W       = 16,
  parameter logic [TO_W-1:0]      TIMEOUT    = 16'd50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             domain,
  input  logic             start,
  output logic             busy,
  output logic [7:0]       rd_data,
  output logic [IDX_W-1:0] rd_idx,
  output logic             valid,
  output logic             err,
  output logic             done,
  i2c_multi_read_seq_if.master bus
);
  typedef enum logic [2:0] {IDLE, SCAN, ISSUE, WAIT, FINISH} state_t;
  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             cur_dom, cur_dom_n;
  logic [TO_W-1:0]  timer, timer_n;
  logic             last, hit, fin;
  // next-state logic: walk the table one slot per cycle, wait on the bus for matching slaves
  always_comb begin
    last = idx == IDX_W'(NUM_SLV - 1);
    hit = SLV_DOMAIN[idx] == cur_dom;
    fin = state == WAIT && (bus.sys_done || timer == TIMEOUT - 1'b1);
    state_n = state;
    idx_n = idx;
    cur_dom_n = cur_dom;
    timer_n = timer;
    case (state)
      IDLE: if (start) begin
        state_n = SCAN;
        idx_n = '0;
        cur_dom_n = domain;
      end
      SCAN: begin
        state_n = hit ? ISSUE : last ? FINISH : SCAN;
        idx_n = hit || last ? idx : idx + 1'b1;
      end
      ISSUE: begin
        state_n = WAIT;
        timer_n = '0;
      end
      WAIT: begin
        timer_n = timer + 1'b1;
        state_n = !fin ? WAIT : last ? FINISH : SCAN;
        idx_n = fin && !last ? idx + 1'b1 : idx;
      end
      default: state_n = IDLE;
    endcase
  end
  // state and registered outputs; sys_done beats a simultaneous timeout, address holds outside ISSUE/WAIT
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      cur_dom <= 1'b0;
      timer <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      valid <= 1'b0;
      err <= 1'b0;
      rd_data <= 8'h00;
      rd_idx <= '0;
      bus.sys_start <= 1'b0;
      bus.sys_slave_addr <= 7'h00;
    end else begin
      state <= state_n;
      idx <= idx_n;
      cur_dom <= cur_dom_n;
      timer <= timer_n;
      busy <= state_n != IDLE;
      done <= state == FINISH;
      valid <= fin;
      err <= fin && !bus.sys_done;
      rd_data <= fin && bus.sys_done ? bus.sys_rd_data : 8'h00;
      rd_idx <= fin ? idx : rd_idx;
      bus.sys_start <= state == SCAN && hit;
      bus.sys_slave_addr <= state == SCAN && hit ? SLV_ADDRS[7*int'(idx) +: 7] : bus.sys_slave_addr;
    end
  end
endmodule

// File: tb/tb_i2c_multi_read_seq.sv
// tb_i2c_multi_read_seq: directed scenarios against a behavioural i2c_sys_top slave model
module tb_i2c_multi_read_seq;
  logic clk = 0, rst = 1, domain = 0, start = 0, domain_b = 0, start_b = 0;
  logic busy_a, valid_a, err_a, done_a, busy_b, valid_b, err_b, done_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic [1:0] rd_idx_a, rd_idx_b;
  int checks = 0, failures = 0;
  i2c_multi_read_seq_if bus_a ();
  i2c_multi_read_seq_if bus_b ();

  always #5 clk = ~clk;

  i2c_multi_read_seq #(.TIMEOUT(16'd20)) u_a (
    .clk(clk), .rst(rst), .domain(domain), .start(start), .busy(busy_a), .rd_data(rd_data_a),
    .rd_idx(rd_idx_a), .valid(valid_a), .err(err_a), .done(done_a), .bus(bus_a));

  i2c_multi_read_seq #(.TIMEOUT(16'd20), .SLV_DOMAIN(4'b0000)) u_b (
    .clk(clk), .rst(rst), .domain(domain_b), .start(start_b), .busy(busy_b), .rd_data(rd_data_b),
    .rd_idx(rd_idx_b), .valid(valid_b), .err(err_b), .done(done_b), .bus(bus_b));

  initial begin
    bus_b.sys_done = 0;
    bus_b.sys_rd_data = 0;
  end

  // slave model: answers dly_norm cycles after sys_start, with one configurable special address
  int dly_norm = 10, sp_dly = 10;
  logic [6:0] sp_addr = 7'h7f;
  logic [7:0] sp_data = 0;
  logic sp_silent = 0;

  function automatic logic [7:0] data_of(input logic [6:0] a);
    return a == 7'h10 ? 8'h12 : a == 7'h20 ? 8'h9C : a == 7'h30 ? 8'h56 : a == 7'h40 ? 8'h3E : 8'h00;
  endfunction

  initial begin
    logic pend;
    int cnt;
    logic [7:0] pdata;
    pend = 0;
    cnt = 0;
    pdata = 0;
    bus_a.sys_done = 0;
    bus_a.sys_rd_data = 8'hEE;
    forever begin
      @(negedge clk);
      bus_a.sys_done = 0;
      bus_a.sys_rd_data = 8'hEE;
      if (rst) pend = 0;
      else if (pend) begin
        cnt--;
        if (cnt == 0) begin
          pend = 0;
          bus_a.sys_done = 1;
          bus_a.sys_rd_data = pdata;
        end
      end
      if (!rst && bus_a.sys_start && !(sp_silent && bus_a.sys_slave_addr == sp_addr)) begin
        pend = 1;
        cnt = bus_a.sys_slave_addr == sp_addr ? sp_dly : dly_norm;
        pdata = bus_a.sys_slave_addr == sp_addr ? sp_data : data_of(bus_a.sys_slave_addr);
      end
    end
  end

  logic [6:0] s_addr[$];
  int s_cyc[$], v_cyc[$];
  logic [1:0] v_idx[$];
  logic [7:0] v_dat[$];
  logic v_err[$];
  int done_cnt, done_cyc, rd_nz;

  // one scan on DUT A; cycle 0 is the start cycle, domain is flipped right after acceptance
  task automatic scan(input logic dom, input int budget);
    s_addr.delete(); s_cyc.delete(); v_cyc.delete(); v_idx.delete(); v_dat.delete(); v_err.delete();
    done_cnt = 0; done_cyc = -1; rd_nz = 0;
    @(negedge clk);
    domain = dom;
    start = 1;
    for (int n = 1; n <= budget; n++) begin
      @(negedge clk);
      if (n == 1) begin
        start = 0;
        domain = ~dom;
      end
      if (bus_a.sys_start) begin s_addr.push_back(bus_a.sys_slave_addr); s_cyc.push_back(n); end
      if (valid_a) begin
        v_idx.push_back(rd_idx_a); v_dat.push_back(rd_data_a); v_err.push_back(err_a); v_cyc.push_back(n);
      end else if (rd_data_a !== 8'h00) rd_nz++;
      if (done_a) begin done_cnt++; done_cyc = n; end
      if (done_cnt > 0 && n >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy_a, rd_data_a, rd_idx_a, valid_a, err_a, done_a, bus_a.sys_start, bus_a.sys_slave_addr} !== 0) begin
      failures++;
      $display("FAIL reset_a busy=%b data=%h idx=%0d v=%b e=%b d=%b ss=%b addr=%h exp all 0",
               busy_a, rd_data_a, rd_idx_a, valid_a, err_a, done_a, bus_a.sys_start, bus_a.sys_slave_addr);
    end
    checks++;
    if ({busy_b, rd_data_b, valid_b, err_b, done_b, bus_b.sys_start, bus_b.sys_slave_addr} !== 0) begin
      failures++;
      $display("FAIL reset_b busy=%b v=%b d=%b ss=%b exp all 0", busy_b, valid_b, done_b, bus_b.sys_start);
    end
    rst = 0;
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 0 || done_a !== 0) begin
      failures++;
      $display("FAIL idle_after_reset busy=%b done=%b exp 0 0", busy_a, done_a);
    end
  endtask

  task automatic test_domain0(input string tag);
    scan(0, 70);
    checks++;
    if (s_addr.size() != 2 || s_addr[0] !== 7'h10 || s_addr[1] !== 7'h30) begin
      failures++;
      $display("FAIL %s_addr n=%0d a0=%h a1=%h exp 2 10 30", tag, s_addr.size(), s_addr[0], s_addr[1]);
    end
    checks++;
    if (s_cyc.size() != 2 || s_cyc[0] != 2 || s_cyc[1] != 15) begin
      failures++;
      $display("FAIL %s_start_cyc c0=%0d c1=%0d exp 2 15", tag, s_cyc[0], s_cyc[1]);
    end
    checks++;
    if (v_idx.size() != 2 || v_idx[0] !== 2'd0 || v_idx[1] !== 2'd2 || v_err[0] !== 0 || v_err[1] !== 0) begin
      failures++;
      $display("FAIL %s_valid n=%0d i0=%0d i1=%0d e0=%b e1=%b exp 2 0 2 0 0", tag, v_idx.size(), v_idx[0], v_idx[1], v_err[0], v_err[1]);
    end
    checks++;
    if (v_dat[0] !== 8'h12 || v_dat[1] !== 8'h56) begin
      failures++;
      $display("FAIL %s_data d0=%h d1=%h exp 12 56", tag, v_dat[0], v_dat[1]);
    end
    checks++;
    if (v_cyc[0] != 13 || v_cyc[1] != 26) begin
      failures++;
      $display("FAIL %s_valid_cyc c0=%0d c1=%0d exp 13 26", tag, v_cyc[0], v_cyc[1]);
    end
    checks++;
    if (done_cnt != 1 || done_cyc != 28 || rd_nz != 0) begin
      failures++;
      $display("FAIL %s_done n=%0d cyc=%0d rd_nz=%0d exp 1 28 0", tag, done_cnt, done_cyc, rd_nz);
    end
  endtask

  task automatic test_domain1;
    scan(1, 70);
    checks++;
    if (s_addr.size() != 2 || s_addr[0] !== 7'h20 || s_addr[1] !== 7'h40 || s_cyc[0] != 3 || s_cyc[1] != 16) begin
      failures++;
      $display("FAIL t2_addr n=%0d a0=%h a1=%h c0=%0d c1=%0d exp 2 20 40 3 16", s_addr.size(), s_addr[0], s_addr[1], s_cyc[0], s_cyc[1]);
    end
    checks++;
    if (v_idx.size() != 2 || v_idx[0] !== 2'd1 || v_idx[1] !== 2'd3 || v_dat[0] !== 8'h9C || v_dat[1] !== 8'h3E) begin
      failures++;
      $display("FAIL t2_valid n=%0d i0=%0d i1=%0d d0=%h d1=%h exp 2 1 3 9c 3e", v_idx.size(), v_idx[0], v_idx[1], v_dat[0], v_dat[1]);
    end
    checks++;
    if (v_cyc[0] != 14 || v_cyc[1] != 27 || done_cnt != 1 || done_cyc != 28) begin
      failures++;
      $display("FAIL t2_timing v0=%0d v1=%0d dn=%0d dc=%0d exp 14 27 1 28", v_cyc[0], v_cyc[1], done_cnt, done_cyc);
    end
  endtask

  task automatic test_timeout;
    sp_addr = 7'h30; sp_silent = 1;
    scan(0, 80);
    sp_silent = 0; sp_addr = 7'h7f;
    checks++;
    if (v_idx.size() != 2 || v_idx[0] !== 2'd0 || v_dat[0] !== 8'h12 || v_err[0] !== 0) begin
      failures++;
      $display("FAIL t3_first n=%0d i=%0d d=%h e=%b exp 2 0 12 0", v_idx.size(), v_idx[0], v_dat[0], v_err[0]);
    end
    checks++;
    if (v_idx[1] !== 2'd2 || v_dat[1] !== 8'h00 || v_err[1] !== 1) begin
      failures++;
      $display("FAIL t3_timeout i=%0d d=%h e=%b exp 2 00 1", v_idx[1], v_dat[1], v_err[1]);
    end
    checks++;
    if (v_cyc[1] != 36 || done_cnt != 1 || done_cyc != 38 || rd_nz != 0) begin
      failures++;
      $display("FAIL t3_timing v1=%0d dn=%0d dc=%0d rd_nz=%0d exp 36 1 38 0", v_cyc[1], done_cnt, done_cyc, rd_nz);
    end
  endtask

  task automatic test_done_vs_timeout;
    sp_addr = 7'h30; sp_dly = 20; sp_data = 8'hA5;
    scan(0, 80);
    sp_addr = 7'h7f; sp_dly = 10;
    checks++;
    if (v_idx.size() != 2 || v_idx[1] !== 2'd2 || v_dat[1] !== 8'hA5 || v_err[1] !== 0) begin
      failures++;
      $display("FAIL t4_race n=%0d i=%0d d=%h e=%b exp 2 2 a5 0", v_idx.size(), v_idx[1], v_dat[1], v_err[1]);
    end
    checks++;
    if (v_cyc[1] != 36 || done_cyc != 38) begin
      failures++;
      $display("FAIL t4_timing v1=%0d dc=%0d exp 36 38", v_cyc[1], done_cyc);
    end
  endtask

  task automatic test_no_match;
    int nstart = 0, nvalid = 0, dn = 0, dcyc = -1;
    logic busy1 = 0, busy6 = 1;
    @(negedge clk);
    domain_b = 1;
    start_b = 1;
    for (int n = 1; n <= 14; n++) begin
      @(negedge clk);
      start_b = n == 2 || n == 4;
      if (n == 1) busy1 = busy_b;
      if (n == 6) busy6 = busy_b;
      if (bus_b.sys_start) nstart++;
      if (valid_b) nvalid++;
      if (done_b) begin dn++; dcyc = n; end
    end
    checks++;
    if (nstart != 0 || nvalid != 0) begin
      failures++;
      $display("FAIL t5_silent sys_start=%0d valid=%0d exp 0 0", nstart, nvalid);
    end
    checks++;
    if (dn != 1 || dcyc != 6) begin
      failures++;
      $display("FAIL t5_done n=%0d cyc=%0d exp 1 6", dn, dcyc);
    end
    checks++;
    if (busy1 !== 1 || busy6 !== 0) begin
      failures++;
      $display("FAIL t5_busy c1=%b c6=%b exp 1 0", busy1, busy6);
    end
  endtask

  task automatic test_back_to_back;
    int sc = -1, dn = -1;
    logic got = 0;
    logic [6:0] sa = 0;
    @(negedge clk);
    domain = 1;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(negedge clk);
      if (done_a) begin got = 1; domain = 0; start = 1; end
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL b2b_first_done got=0 exp 1");
    end
    for (int m = 1; m <= 10; m++) begin
      @(negedge clk);
      if (m == 1) start = 0;
      if (bus_a.sys_start && sc < 0) begin sc = m; sa = bus_a.sys_slave_addr; end
    end
    checks++;
    if (sc != 2 || sa !== 7'h10) begin
      failures++;
      $display("FAIL b2b_restart cyc=%0d addr=%h exp 2 10", sc, sa);
    end
    for (int n = 0; n < 60 && dn < 0; n++) begin
      @(negedge clk);
      if (done_a) dn = n;
    end
    checks++;
    if (dn < 0) begin
      failures++;
      $display("FAIL b2b_second_done got=none exp pulse");
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_in_wait;
    @(negedge clk);
    domain = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (4) @(negedge clk);
    checks++;
    if (busy_a !== 1 || bus_a.sys_slave_addr !== 7'h10) begin
      failures++;
      $display("FAIL t6_pre busy=%b addr=%h exp 1 10", busy_a, bus_a.sys_slave_addr);
    end
    #1 rst = 1;
    #1;
    checks++;
    if ({busy_a, rd_data_a, rd_idx_a, valid_a, err_a, done_a, bus_a.sys_start, bus_a.sys_slave_addr} !== 0) begin
      failures++;
      $display("FAIL t6_async busy=%b addr=%h v=%b d=%b exp all 0", busy_a, bus_a.sys_slave_addr, valid_a, done_a);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy_a !== 0 || bus_a.sys_slave_addr !== 7'h00) begin
      failures++;
      $display("FAIL t6_hold busy=%b addr=%h exp 0 00", busy_a, bus_a.sys_slave_addr);
    end
    rst = 0;
    repeat (15) @(negedge clk);
    test_domain0("t6");
  endtask

  initial begin
    test_reset();
    test_domain0("t1");
    test_domain1();
    test_timeout();
    test_done_vs_timeout();
    test_no_match();
    test_back_to_back();
    test_reset_in_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
